// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: packs field-level requests into 32-bit instruction words
// with byte addresses, substituting a flagged NOP for illegal requests.
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    fmt_e        fmt;
    logic        is_shift;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [11:0] imm_i;
    logic [31:0] enc_word;
    logic        enc_legal;

    logic [31:0]       mem_instr [0:1];
    logic [ADDR_W-1:0] mem_addr  [0:1];
    logic              mem_err   [0:1];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] next_addr;
    logic [ERR_W-1:0]  err_q;
    logic              push;
    logic              pop;

    always_comb begin
        fmt = FMT_BAD;
        case (in_opcode)
            7'b0110011:                                     fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b0001111, 7'b1100111: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_BAD;
        endcase
    end

    // Range checks: the upper bits must all replicate the top bit of the encodable field.
    always_comb begin
        is_shift = (in_opcode == 7'b0010011) && (in_funct3 == 3'b001 || in_funct3 == 3'b101);
        fits12   = (in_imm[31:11] == {21{in_imm[11]}});
        fits13   = (in_imm[31:12] == {20{in_imm[12]}});
        fits21   = (in_imm[31:20] == {12{in_imm[20]}});
        imm_i    = is_shift ? {1'b0, in_funct7[5], 5'b0, in_imm[4:0]} : in_imm[11:0];
    end

    always_comb begin
        enc_word  = NOP;
        enc_legal = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_legal = 1'b1;
                enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_I: begin
                enc_legal = is_shift || fits12;
                enc_word  = {imm_i, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_S: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            FMT_B: begin
                enc_legal = fits13 && !in_imm[0];
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
            end
            FMT_U: begin
                enc_legal = (in_imm[11:0] == 12'd0);
                enc_word  = {in_imm[31:12], in_rd, in_opcode};
            end
            FMT_J: begin
                enc_legal = fits21 && !in_imm[0];
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            default: begin
                enc_legal = 1'b0;
                enc_word  = NOP;
            end
        endcase
        if (!enc_legal) begin
            enc_word = NOP;
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !clr;
    assign pop       = out_valid && out_ready && !clr;

    assign out_instr = mem_instr[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];
    assign out_err   = mem_err[rd_ptr];
    assign err_cnt   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_instr[i] <= '0;
                mem_addr[i]  <= '0;
                mem_err[i]   <= 1'b0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= enc_word;
            mem_addr[wr_ptr]  <= next_addr;
            mem_err[wr_ptr]   <= !enc_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Illegal requests still take an address slot, so the address advances on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_addr <= BASE_ADDR;
            err_q     <= '0;
        end else if (clr) begin
            next_addr <= BASE_ADDR;
            err_q     <= '0;
        end else if (push) begin
            next_addr <= next_addr + ADDR_W'(4);
            if (!enc_legal && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized and directed bench for rv32i_instr_encoder against a queue-based reference model.
module tb_rv32i_instr_encoder;

    localparam int          ADDR_W = 32;
    localparam int          ERR_W  = 8;
    localparam logic [31:0] BASE   = 32'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        in_opcode = '0;
    logic [2:0]        in_funct3 = '0;
    logic [6:0]        in_funct7 = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [ERR_W-1:0]  err_cnt;

    rv32i_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_addr = BASE;
    int          m_err = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference encoder written from the format tables using plain arithmetic.
    function automatic logic [32:0] model_encode(input logic [6:0] op, input logic [2:0] f3,
                                                 input logic [6:0] f7, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [31:0] imm);
        logic [31:0] o, f3w, f7w, rdw, s1, s2, t, w;
        int          si;
        logic        ok;
        o = 32'(op); f3w = 32'(f3); f7w = 32'(f7); rdw = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
        si = $signed(imm);
        ok = 1'b1;
        w  = 32'h0;
        case (op)
            7'h33: w = f7w * 33554432 + s2 * 1048576 + s1 * 32768 + f3w * 4096 + rdw * 128 + o;
            7'h13, 7'h03, 7'h0F, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    t = (f7[5] ? 32'd1024 : 32'd0) + imm % 32;
                end else begin
                    ok = (si >= -2048) && (si <= 2047);
                    t  = imm % 4096;
                end
                w = t * 1048576 + s1 * 32768 + f3w * 4096 + rdw * 128 + o;
            end
            7'h23: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = ((imm / 32) % 128) * 33554432 + s2 * 1048576 + s1 * 32768 + f3w * 4096
                     + (imm % 32) * 128 + o;
            end
            7'h63: begin
                ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                w  = ((imm / 4096) % 2) * 32'h8000_0000 + ((imm / 32) % 64) * 33554432
                     + s2 * 1048576 + s1 * 32768 + f3w * 4096 + ((imm / 2) % 16) * 256
                     + ((imm / 2048) % 2) * 128 + o;
            end
            7'h37, 7'h17: begin
                ok = (imm % 4096 == 0);
                w  = imm - imm % 4096 + rdw * 128 + o;
            end
            7'h6F: begin
                ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
                w  = ((imm / 1048576) % 2) * 32'h8000_0000 + ((imm / 2) % 1024) * 2097152
                     + ((imm / 2048) % 2) * 1048576 + ((imm / 4096) % 256) * 4096 + rdw * 128 + o;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) w = 32'h13;
        return {!ok, w};
    endfunction

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Advance the model by the handshake implied by the current inputs, then one clock.
    task automatic tick();
        logic [32:0] e;
        entry_t      ent;
        logic        do_push;
        logic        do_pop;
        if (clr) begin
            q.delete(); m_addr = BASE; m_err = 0;
        end else begin
            do_push = in_valid && (q.size() != 2);
            do_pop  = out_ready && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e = model_encode(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                ent.instr = e[31:0]; ent.addr = m_addr; ent.err = e[32];
                q.push_back(ent);
                m_addr = m_addr + 32'd4;
                if (e[32] && m_err < 255) m_err++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr: got %h expected 00000000", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_addr: got %h expected 00000000", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b0;
        set_req(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_instr !== 32'h002081B3) begin errors++; $display("[TB] FAIL add_instr: got %h expected 002081b3", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("[TB] FAIL add_addr: got %h expected 00000000", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL add_err: got %b expected 0", out_err); end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        out_ready = 1'b1;
        set_req(7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1; tick();
        checks++; if (out_instr !== 32'hFFF00293 || out_addr !== 32'h0) begin errors++; $display("[TB] FAIL addi_word: got %h@%h expected fff00293@00000000", out_instr, out_addr); end
        set_req(7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
        tick(); in_valid = 1'b0;
        checks++; if (out_instr !== 32'h123450B7 || out_addr !== 32'h4) begin errors++; $display("[TB] FAIL lui_word: got %h@%h expected 123450b7@00000004", out_instr, out_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL lui_valid: got %b expected 1", out_valid); end
        tick();
    endtask

    task automatic test_branch();
        do_clr();
        out_ready = 1'b1;
        set_req(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        in_valid = 1'b1; tick();
        checks++; if (out_instr !== 32'h00208463 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL beq_word: got %h err %b expected 00208463 err 0", out_instr, out_err); end
        in_imm = 32'h1000; tick(); in_valid = 1'b0;
        checks++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin errors++; $display("[TB] FAIL beq_range: got %h err %b expected 00000013 err 1", out_instr, out_err); end
        checks++; if (out_addr !== 32'h4) begin errors++; $display("[TB] FAIL beq_range_addr: got %h expected 00000004", out_addr); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL beq_err_cnt: got %0d expected 1", err_cnt); end
        tick();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_clr();
        out_ready = 1'b1;
        set_req(7'b1111111, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            checks++; if (out_instr !== 32'h13 || out_err !== 1'b1) begin errors++; $display("[TB] FAIL sat_nop[%0d]: got %h err %b expected 00000013 err 1", i, out_instr, out_err); end
            checks++; if (err_cnt !== 8'(exp_cnt) || out_addr !== 32'(i * 4)) begin errors++; $display("[TB] FAIL sat_cnt[%0d]: got cnt %0d addr %h expected cnt %0d addr %h", i, err_cnt, out_addr, exp_cnt, i * 4); end
        end
        in_valid = 1'b0; tick();
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_final: got %0d expected 255", err_cnt); end
    endtask

    task automatic test_backpressure();
        do_clr();
        out_ready = 1'b0;
        set_req(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1; tick();
        set_req(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        tick();
        set_req(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full: got in_ready %b expected 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00100093 || out_addr !== 32'h0) begin errors++; $display("[TB] FAIL bp_hold: got rdy %b %h@%h expected rdy 0 00100093@00000000", in_ready, out_instr, out_addr); end
        out_ready = 1'b1; tick();
        checks++; if (in_ready !== 1'b1 || out_instr !== 32'h00200113 || out_addr !== 32'h4) begin errors++; $display("[TB] FAIL bp_pop1: got rdy %b %h@%h expected rdy 1 00200113@00000004", in_ready, out_instr, out_addr); end
        tick(); in_valid = 1'b0;
        checks++; if (out_instr !== 32'h00300193 || out_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_third: got %h@%h expected 00300193@00000008", out_instr, out_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        set_req(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        q.delete(); m_addr = BASE; m_err = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_drop: got valid %b rdy %b expected valid 0 rdy 1", out_valid, in_ready); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        set_req(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (out_addr !== BASE || out_instr !== 32'h00300193) begin errors++; $display("[TB] FAIL midrst_addr: got %h@%h expected 00300193@%h", out_instr, out_addr, BASE); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b0;
        set_req(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1; tick();
        set_req(7'b1111111, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        clr = 1'b1; tick(); clr = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clr_flush: got valid %b cnt %0d expected valid 0 cnt 0", out_valid, err_cnt); end
        set_req(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (out_addr !== BASE || out_instr !== 32'h00300193) begin errors++; $display("[TB] FAIL clr_addr: got %h@%h expected 00300193@%h", out_instr, out_addr, BASE); end
        out_ready = 1'b1; tick();
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 11))
            0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0000011;
            3: return 7'b0001111;  4: return 7'b1100111;  5: return 7'b0100011;
            6: return 7'b1100011;  7: return 7'b0110111;  8: return 7'b0010111;
            9: return 7'b1101111;  10: return 7'b0010011;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        int v;
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: begin v = $urandom_range(0, 4095); return 32'(v - 2048); end
            2: begin v = $urandom_range(0, 4095); return 32'(2 * v - 4096); end
            3: begin v = $urandom_range(0, 1048575); return 32'(2 * v - 1048576); end
            4: return $urandom & 32'hFFFF_F000;
            default: begin
                case ($urandom_range(0, 9))
                    0: return 32'd2047;  1: return -32'sd2048;  2: return 32'd2048;
                    3: return -32'sd2049; 4: return 32'd4094;  5: return -32'sd4096;
                    6: return 32'd4096;  7: return 32'd1048574; 8: return -32'sd1048576;
                    default: return 32'd1048576;
                endcase
            end
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_req(rand_op(), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            tick();
            clr = 1'b0;
            checks++; if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_flags[%0d]: got rdy %b valid %b expected rdy %b valid %b", i, in_ready, out_valid, q.size() != 2, q.size() != 0); end
            checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("[TB] FAIL rnd_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, m_err); end
            if (q.size() != 0) begin
                checks++; if (out_instr !== q[0].instr || out_addr !== q[0].addr || out_err !== q[0].err) begin errors++; $display("[TB] FAIL rnd_head[%0d]: got %h@%h err %b expected %h@%h err %b", i, out_instr, out_addr, out_err, q[0].instr, q[0].addr, q[0].err); end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
